// File: rtl/vm_multi_ctrl.sv
// vm_multi_ctrl: N-slot vending controller with restock, coin collection, watchdog abort and
// refund. Define VM_COIN_CHANGE_EN to return change coin-by-coin instead of as a lump sum.
module vm_multi_ctrl #(
   parameter int unsigned N_ITEMS   = 8,
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned MAX_STOCK = 16,
   parameter int unsigned COST_W    = 8,
   parameter int unsigned AMT_W     = 12,
   parameter int unsigned TIMEOUT   = 255,
   localparam int unsigned IDX_W    = $clog2(N_ITEMS)
) (
   input  logic              clk,
   input  logic              hrst_n,
   input  logic              rs_valid,
   input  logic [IDX_W-1:0]  rs_item,
   input  logic [CNT_W-1:0]  rs_count,
   input  logic [COST_W-1:0] rs_cost,
   input  logic              sel_valid,
   input  logic [IDX_W-1:0]  sel_item,
   input  logic [1:0]        coin,
   input  logic              confirm,
   input  logic              cancel,
   output logic              product_valid,
   output logic [IDX_W-1:0]  product_id,
   output logic [2:0]        status,
   output logic [COST_W-1:0] price,
   output logic [AMT_W-1:0]  amount,
   output logic              change_valid,
   output logic [1:0]        change_coin,
   output logic              busy
);

   localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [2:0] StsNone    = 3'd0;
   localparam logic [2:0] StsAvail   = 3'd1;
   localparam logic [2:0] StsOos     = 3'd2;
   localparam logic [2:0] StsError   = 3'd3;
   localparam logic [2:0] StsInsuff  = 3'd4;
   localparam logic [2:0] StsTimeout = 3'd5;
   localparam logic [2:0] StsRefund  = 3'd6;

   typedef enum logic [2:0] {StIdle, StRestock, StCheck, StCollect, StVend, StChange} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  stock_q [N_ITEMS];
   logic [CNT_W-1:0]  stock_d [N_ITEMS];
   logic [COST_W-1:0] cost_q  [N_ITEMS];
   logic [COST_W-1:0] cost_d  [N_ITEMS];
   logic [IDX_W-1:0]  slot_q, slot_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;

   logic              product_valid_d, change_valid_d, busy_d;
   logic [IDX_W-1:0]  product_id_d;
   logic [2:0]        status_d;
   logic [COST_W-1:0] price_d;
   logic [AMT_W-1:0]  amount_d;
   logic [1:0]        change_coin_d;

   logic [AMT_W-1:0]  coin_val, credit;
   logic [AMT_W:0]    coin_sum;
   logic [CNT_W:0]    rs_sum;
   logic              rs_item_ok, rs_over;

   always_comb begin
      unique case (coin)
         2'b00: coin_val = AMT_W'(0);
         2'b01: coin_val = AMT_W'(5);
         2'b10: coin_val = AMT_W'(10);
         2'b11: coin_val = AMT_W'(25);
      endcase
      coin_sum   = {1'b0, amount} + {1'b0, coin_val};
      // Saturate rather than wrap so a flood of coins can never lose credit.
      credit     = coin_sum[AMT_W] ? '1 : coin_sum[AMT_W-1:0];
      rs_item_ok = 32'(rs_item) < N_ITEMS;
      rs_sum     = {1'b0, stock_q[rs_item]} + {1'b0, rs_count};
      rs_over    = 32'(rs_sum) > MAX_STOCK;
   end

   always_comb begin
      state_d         = state_q;
      stock_d         = stock_q;
      cost_d          = cost_q;
      slot_d          = slot_q;
      wdog_d          = wdog_q;
      product_valid_d = 1'b0;
      product_id_d    = product_id;
      status_d        = status;
      price_d         = price;
      amount_d        = amount;
      change_valid_d  = 1'b0;
      change_coin_d   = 2'b00;
      unique case (state_q)
         StIdle: begin
            status_d = StsNone;
            amount_d = '0;
            if (rs_valid) begin
               state_d = StRestock;
            end else if (sel_valid) begin
               slot_d  = sel_item;
               state_d = StCheck;
            end
         end
         StRestock: begin
            if (!rs_valid) begin
               state_d = StIdle;
            end else if (!rs_item_ok) begin
               status_d = StsError;
            end else begin
               status_d = rs_over ? StsError : StsNone;
               if (!rs_over) stock_d[rs_item] = rs_sum[CNT_W-1:0];
               if (rs_cost != '0) cost_d[rs_item] = rs_cost;
            end
         end
         StCheck: begin
            if (stock_q[slot_q] != '0) begin
               status_d = StsAvail;
               price_d  = cost_q[slot_q];
               wdog_d   = WD_W'(TIMEOUT);
               state_d  = StCollect;
            end else begin
               status_d = StsOos;
               state_d  = StIdle;
            end
         end
         StCollect: begin
            amount_d = credit;
            if (coin != 2'b00) wdog_d = WD_W'(TIMEOUT);
            else if (wdog_q != '0) wdog_d = wdog_q - WD_W'(1);
            if (cancel) begin
               status_d = StsRefund;
               state_d  = StChange;
            end else if (wdog_q == '0) begin
               status_d = StsTimeout;
               state_d  = StChange;
            end else if (confirm) begin
               if (credit >= AMT_W'(price)) state_d = StVend;
               else status_d = StsInsuff;
            end
         end
         StVend: begin
            product_valid_d = 1'b1;
            product_id_d    = slot_q;
            stock_d[slot_q] = stock_q[slot_q] - CNT_W'(1);
            amount_d        = amount - AMT_W'(price);
            state_d         = (amount_d != '0) ? StChange : StIdle;
         end
         StChange: begin
`ifdef VM_COIN_CHANGE_EN
            change_valid_d = 1'b1;
            if (amount >= AMT_W'(25)) begin
               change_coin_d = 2'b11;
               amount_d      = amount - AMT_W'(25);
            end else if (amount >= AMT_W'(10)) begin
               change_coin_d = 2'b10;
               amount_d      = amount - AMT_W'(10);
            end else if (amount >= AMT_W'(5)) begin
               change_coin_d = 2'b01;
               amount_d      = amount - AMT_W'(5);
            end else begin
               change_valid_d = 1'b0;
            end
            // Sub-nickel residue cannot be paid out; drop it and finish.
            if (amount_d < AMT_W'(5)) begin
               amount_d = '0;
               state_d  = StIdle;
            end
`else
            // Lump-sum return: amount stays visible with the pulse, IDLE clears it.
            change_valid_d = 1'b1;
            state_d        = StIdle;
`endif
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!hrst_n) begin
         state_q       <= StIdle;
         stock_q       <= '{default: '0};
         cost_q        <= '{default: '0};
         slot_q        <= '0;
         wdog_q        <= '0;
         product_valid <= 1'b0;
         product_id    <= '0;
         status        <= StsNone;
         price         <= '0;
         amount        <= '0;
         change_valid  <= 1'b0;
         change_coin   <= 2'b00;
         busy          <= 1'b0;
      end else begin
         state_q       <= state_d;
         stock_q       <= stock_d;
         cost_q        <= cost_d;
         slot_q        <= slot_d;
         wdog_q        <= wdog_d;
         product_valid <= product_valid_d;
         product_id    <= product_id_d;
         status        <= status_d;
         price         <= price_d;
         amount        <= amount_d;
         change_valid  <= change_valid_d;
         change_coin   <= change_coin_d;
         busy          <= busy_d;
      end
   end

endmodule

// File: tb/tb_vm_multi_ctrl.sv
// Directed self-checking bench for vm_multi_ctrl (default parameters, either change mode).
module tb_vm_multi_ctrl;

   localparam logic [2:0] S_NONE = 3'd0, S_AVAIL = 3'd1, S_OOS = 3'd2, S_ERR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4, S_TMO = 3'd5, S_REF = 3'd6;

   logic        clk = 1'b0;
   logic        hrst_n;
   logic        rs_valid;
   logic [2:0]  rs_item;
   logic [4:0]  rs_count;
   logic [7:0]  rs_cost;
   logic        sel_valid;
   logic [2:0]  sel_item;
   logic [1:0]  coin;
   logic        confirm;
   logic        cancel;
   logic        product_valid;
   logic [2:0]  product_id;
   logic [2:0]  status;
   logic [7:0]  price;
   logic [11:0] amount;
   logic        change_valid;
   logic [1:0]  change_coin;
   logic        busy;

   int checks = 0;
   int failures = 0;

   vm_multi_ctrl dut (
      .clk(clk), .hrst_n(hrst_n),
      .rs_valid(rs_valid), .rs_item(rs_item), .rs_count(rs_count), .rs_cost(rs_cost),
      .sel_valid(sel_valid), .sel_item(sel_item), .coin(coin),
      .confirm(confirm), .cancel(cancel),
      .product_valid(product_valid), .product_id(product_id), .status(status),
      .price(price), .amount(amount), .change_valid(change_valid),
      .change_coin(change_coin), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL global_timeout sim time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rs_open();
      rs_valid = 1'b1; rs_item = 3'd0; rs_count = 5'd0; rs_cost = 8'd0;
      tick();
   endtask

   task automatic rs_write(input logic [2:0] item, input logic [4:0] cnt, input logic [7:0] cst);
      rs_item = item; rs_count = cnt; rs_cost = cst;
      tick();
   endtask

   task automatic rs_close();
      rs_valid = 1'b0; rs_count = 5'd0; rs_cost = 8'd0;
      tick();
      tick();
   endtask

   task automatic select(input logic [2:0] item);
      sel_valid = 1'b1; sel_item = item;
      tick();
      sel_valid = 1'b0;
      tick();
   endtask

   task automatic put_coin(input logic [1:0] c);
      coin = c;
      tick();
      coin = 2'b00;
   endtask

   task automatic press_confirm();
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
   endtask

   task automatic test_reset();
      hrst_n = 1'b0; rs_valid = 1'b0; rs_item = '0; rs_count = '0; rs_cost = '0;
      sel_valid = 1'b0; sel_item = '0; coin = 2'b00; confirm = 1'b0; cancel = 1'b0;
      tick();
      tick();
      checks++;
      if ({product_valid, product_id, status, price, amount, change_valid, change_coin, busy}
          !== '0) begin
         failures++;
         $display("FAIL reset_outputs pv=%0d id=%0d st=%0d pr=%0d amt=%0d cv=%0d cc=%0d busy=%0d",
                  product_valid, product_id, status, price, amount, change_valid, change_coin,
                  busy);
      end
      hrst_n = 1'b1;
      tick();
   endtask

   task automatic test_restock();
      rs_open();
      rs_write(3'd2, 5'd10, 8'd35);
      checks++;
      if (status !== S_NONE) begin
         failures++; $display("FAIL restock_ok status=%0d exp=%0d", status, S_NONE);
      end
      rs_write(3'd2, 5'd7, 8'd0);
      checks++;
      if (status !== S_ERR) begin
         failures++; $display("FAIL restock_overflow status=%0d exp=%0d", status, S_ERR);
      end
      rs_close();
      checks++;
      if (status !== S_NONE || busy !== 1'b0) begin
         failures++; $display("FAIL restock_exit status=%0d busy=%0d exp 0/0", status, busy);
      end
   endtask

   task automatic test_exact_pay();
      put_coin(2'b11);
      checks++;
      if (amount !== 12'd0) begin
         failures++; $display("FAIL idle_coin_ignored amount=%0d exp=0", amount);
      end
      select(3'd2);
      checks++;
      if (status !== S_AVAIL || price !== 8'd35 || busy !== 1'b1) begin
         failures++;
         $display("FAIL check_avail status=%0d price=%0d busy=%0d exp 1/35/1", status, price, busy);
      end
      put_coin(2'b11);
      checks++;
      if (amount !== 12'd25) begin
         failures++; $display("FAIL coin_quarter amount=%0d exp=25", amount);
      end
      put_coin(2'b10);
      checks++;
      if (amount !== 12'd35) begin
         failures++; $display("FAIL coin_dime amount=%0d exp=35", amount);
      end
      press_confirm();
      checks++;
      if (product_valid !== 1'b0) begin
         failures++; $display("FAIL vend_early product_valid=%0d exp=0", product_valid);
      end
      tick();
      checks++;
      if (product_valid !== 1'b1 || product_id !== 3'd2 || amount !== 12'd0 ||
          change_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL exact_vend pv=%0d id=%0d amt=%0d cv=%0d busy=%0d exp 1/2/0/0/0",
                  product_valid, product_id, amount, change_valid, busy);
      end
      tick();
      checks++;
      if (product_valid !== 1'b0 || change_valid !== 1'b0) begin
         failures++;
         $display("FAIL exact_after pv=%0d cv=%0d exp 0/0", product_valid, change_valid);
      end
      // Stock must now be 9: +7 fits exactly, a further +1 overflows.
      rs_open();
      rs_write(3'd2, 5'd7, 8'd0);
      checks++;
      if (status !== S_NONE) begin
         failures++; $display("FAIL stock9_fill status=%0d exp=%0d", status, S_NONE);
      end
      rs_write(3'd2, 5'd1, 8'd0);
      checks++;
      if (status !== S_ERR) begin
         failures++; $display("FAIL stock9_over status=%0d exp=%0d", status, S_ERR);
      end
      rs_close();
   endtask

   task automatic test_insufficient();
      select(3'd2);
      put_coin(2'b11);
      press_confirm();
      checks++;
      if (status !== S_INS || amount !== 12'd25 || busy !== 1'b1) begin
         failures++;
         $display("FAIL insufficient status=%0d amt=%0d busy=%0d exp 4/25/1", status, amount, busy);
      end
      put_coin(2'b10);
      press_confirm();
      tick();
      checks++;
      if (product_valid !== 1'b1 || product_id !== 3'd2 || amount !== 12'd0) begin
         failures++;
         $display("FAIL topup_vend pv=%0d id=%0d amt=%0d exp 1/2/0", product_valid, product_id,
                  amount);
      end
      tick();
   endtask

   task automatic test_change();
      select(3'd2);
      put_coin(2'b11);
      put_coin(2'b11);
      put_coin(2'b11);
      checks++;
      if (amount !== 12'd75) begin
         failures++; $display("FAIL change_credit amount=%0d exp=75", amount);
      end
      press_confirm();
      tick();
      checks++;
      if (product_valid !== 1'b1 || amount !== 12'd40 || busy !== 1'b1) begin
         failures++;
         $display("FAIL change_vend pv=%0d amt=%0d busy=%0d exp 1/40/1", product_valid, amount,
                  busy);
      end
`ifdef VM_COIN_CHANGE_EN
      tick();
      checks++;
      if (change_valid !== 1'b1 || change_coin !== 2'b11 || amount !== 12'd15) begin
         failures++;
         $display("FAIL change_q cv=%0d coin=%0d amt=%0d exp 1/3/15", change_valid, change_coin,
                  amount);
      end
      tick();
      checks++;
      if (change_valid !== 1'b1 || change_coin !== 2'b10 || amount !== 12'd5) begin
         failures++;
         $display("FAIL change_d cv=%0d coin=%0d amt=%0d exp 1/2/5", change_valid, change_coin,
                  amount);
      end
      tick();
      checks++;
      if (change_valid !== 1'b1 || change_coin !== 2'b01 || amount !== 12'd0) begin
         failures++;
         $display("FAIL change_n cv=%0d coin=%0d amt=%0d exp 1/1/0", change_valid, change_coin,
                  amount);
      end
`else
      tick();
      checks++;
      if (change_valid !== 1'b1 || change_coin !== 2'b00 || amount !== 12'd40) begin
         failures++;
         $display("FAIL change_lump cv=%0d coin=%0d amt=%0d exp 1/0/40", change_valid,
                  change_coin, amount);
      end
`endif
      tick();
      checks++;
      if (change_valid !== 1'b0 || amount !== 12'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL change_done cv=%0d amt=%0d busy=%0d exp 0/0/0", change_valid, amount, busy);
      end
   endtask

   task automatic test_cancel();
      select(3'd2);
      put_coin(2'b10);
      cancel = 1'b1; confirm = 1'b1;
      tick();
      cancel = 1'b0; confirm = 1'b0;
      checks++;
      if (status !== S_REF || amount !== 12'd10) begin
         failures++; $display("FAIL cancel_prio status=%0d amt=%0d exp 6/10", status, amount);
      end
      tick();
      checks++;
`ifdef VM_COIN_CHANGE_EN
      if (change_valid !== 1'b1 || change_coin !== 2'b10 || product_valid !== 1'b0) begin
`else
      if (change_valid !== 1'b1 || change_coin !== 2'b00 || product_valid !== 1'b0) begin
`endif
         failures++;
         $display("FAIL cancel_refund cv=%0d coin=%0d pv=%0d", change_valid, change_coin,
                  product_valid);
      end
      tick();
   endtask

   task automatic test_timeout();
      int n;
      select(3'd2);
      put_coin(2'b01);
      n = 0;
      while (status !== S_TMO && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (n != 256) begin
         failures++; $display("FAIL timeout_cycles got=%0d exp=256 status=%0d", n, status);
      end
      checks++;
      if (amount !== 12'd5) begin
         failures++; $display("FAIL timeout_credit amount=%0d exp=5", amount);
      end
      tick();
      checks++;
`ifdef VM_COIN_CHANGE_EN
      if (change_valid !== 1'b1 || change_coin !== 2'b01) begin
`else
      if (change_valid !== 1'b1 || change_coin !== 2'b00 || amount !== 12'd5) begin
`endif
         failures++;
         $display("FAIL timeout_refund cv=%0d coin=%0d amt=%0d", change_valid, change_coin, amount);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || amount !== 12'd0) begin
         failures++; $display("FAIL timeout_idle busy=%0d amt=%0d exp 0/0", busy, amount);
      end
      // Slot 2 should still hold 14 units: +2 fits, a further +1 overflows.
      rs_open();
      rs_write(3'd2, 5'd2, 8'd0);
      checks++;
      if (status !== S_NONE) begin
         failures++; $display("FAIL stock14_fill status=%0d exp=%0d", status, S_NONE);
      end
      rs_write(3'd2, 5'd1, 8'd0);
      checks++;
      if (status !== S_ERR) begin
         failures++; $display("FAIL stock14_over status=%0d exp=%0d", status, S_ERR);
      end
      rs_close();
   endtask

   task automatic test_empty_and_reset();
      select(3'd5);
      checks++;
      if (status !== S_OOS || busy !== 1'b0) begin
         failures++; $display("FAIL empty_slot status=%0d busy=%0d exp 2/0", status, busy);
      end
      tick();
      checks++;
      if (status !== S_NONE) begin
         failures++; $display("FAIL empty_idle status=%0d exp=0", status);
      end
      select(3'd2);
      put_coin(2'b11);
      hrst_n = 1'b0;
      tick();
      checks++;
      if ({product_valid, product_id, status, price, amount, change_valid, change_coin, busy}
          !== '0) begin
         failures++;
         $display("FAIL reset_collect st=%0d pr=%0d amt=%0d cv=%0d busy=%0d", status, price,
                  amount, change_valid, busy);
      end
      hrst_n = 1'b1;
      tick();
      select(3'd2);
      checks++;
      if (status !== S_OOS) begin
         failures++; $display("FAIL reset_stock status=%0d exp=%0d", status, S_OOS);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_restock();
      test_exact_pay();
      test_insufficient();
      test_change();
      test_cancel();
      test_timeout();
      test_empty_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vm_multi_ctrl.md
# vm_multi_ctrl

Parametrised next-generation vending-machine controller: N item slots with per-slot stock and price registers, a coin-accumulating purchase FSM with watchdog timeout, cancel/refund and optional coin-by-coin change return. Sits between the front-panel/coin-acceptor interface and the dispenser/coin-hopper drivers. It replaces the fixed 7-item controller in new builds.

## Interface
- `N_ITEMS`, 8: number of item slots (2..16).
- `CNT_W`, 5: stock counter width.
- `MAX_STOCK`, 16: per-slot capacity.
- `COST_W`, 8: price width, in cents.
- `AMT_W`, 12: inserted-amount accumulator width.
- `TIMEOUT`, 255: idle cycles in COLLECT before abort.
- `clk` in 1: single clock, rising edge.
- `hrst_n` in 1: synchronous, active-low reset.
- `rs_valid` in 1: supplier restock strobe; high for the whole restock session.
- `rs_item` in $clog2(N_ITEMS): slot being restocked.
- `rs_count` in CNT_W: units added this cycle.
- `rs_cost` in COST_W: new price; 0 keeps the current price.
- `sel_valid` in 1: customer selection strobe.
- `sel_item` in $clog2(N_ITEMS): selected slot.
- `coin` in 2: 00 none, 01 nickel (5), 10 dime (10), 11 quarter (25). One coin per cycle.
- `confirm` in 1: customer "select/pay" press.
- `cancel` in 1: customer abort.
- `product_valid` out 1: one-cycle dispense pulse.
- `product_id` out $clog2(N_ITEMS): slot dispensed.
- `status` out 3: 0 NONE, 1 AVAILABLE, 2 OUT_OF_STOCK, 3 ERROR, 4 INSUFFICIENT, 5 TIMEOUT, 6 REFUND.
- `price` out COST_W: price of the selected slot.
- `amount` out AMT_W: credit currently held.
- `change_valid` out 1: one-cycle coin-eject pulse.
- `change_coin` out 2: coin ejected, same encoding as `coin`.
- `busy` out 1: high in every state except IDLE.

## Operation
- State machine: IDLE, RESTOCK, CHECK, COLLECT, VEND, CHANGE.
- IDLE:
  - `rs_valid` goes to RESTOCK.
  - Otherwise `sel_valid` latches `sel_item` and goes to CHECK.
  - `rs_valid` wins when both are asserted.
- RESTOCK:
  - Each cycle, stock[rs_item] += rs_count, unless the sum exceeds MAX_STOCK. In that case stock is unchanged and `status`=ERROR for that cycle.
  - Nonzero `rs_cost` writes price[rs_item].
  - `rs_item` ≥ N_ITEMS gives ERROR with no write.
  - Leave to IDLE when `rs_valid` drops.
- CHECK (1 cycle):
  - stock≠0: `status`=AVAILABLE, `price` loaded, go to COLLECT.
  - stock=0: OUT_OF_STOCK, go to IDLE.
- COLLECT:
  - Each coin adds its value to `amount` and reloads the watchdog to TIMEOUT.
  - Accumulation saturates at 2^AMT_W−1.
  - `confirm`:
    - `amount` ≥ price goes to VEND.
    - Otherwise `status`=INSUFFICIENT, stay in COLLECT, credit retained.
  - `cancel` or watchdog reaching 0 sets `status`=REFUND or TIMEOUT and goes to CHANGE with the full credit.
  - `cancel` has priority over `confirm` in the same cycle.
  - A coin arriving in the same cycle as `confirm` is counted before the comparison.
- VEND (1 cycle):
  - `product_valid`=1, `product_id`=slot.
  - stock[slot] −= 1, `amount` −= price.
  - Go to CHANGE if `amount` is still nonzero, else IDLE.
- CHANGE: returns credit per Configuration; ends in IDLE with `amount`=0.
- `sel_valid`, `coin`, `confirm` and `cancel` outside their states are ignored. Coins outside COLLECT are not credited; the coin acceptor rejects them mechanically.

## Timing
- All outputs are registered.
- Reset values: `product_valid`=0, `product_id`=0, `status`=NONE, `price`=0, `amount`=0, `change_valid`=0, `change_coin`=00, `busy`=0.
- Reset clears all stock and price registers to 0 and forces IDLE.
- Reset in any state abandons credit with no change emitted.
- Latencies:
  - Selection → `status` valid: 2 cycles (IDLE→CHECK register).
  - `confirm` (sufficient) → `product_valid`: 1 cycle after the confirm edge.
  - A coin is reflected in `amount` the cycle after it is sampled.
- Watchdog: a down counter loaded with TIMEOUT on COLLECT entry and on each coin. Timeout fires on the cycle it reads 0.
- `status` holds until the next state that writes it; IDLE writes NONE.

## Configuration
- `VM_COIN_CHANGE_EN` defined:
  - CHANGE ejects one coin per cycle, greedy: quarter while `amount` ≥ 25, then dime, then nickel.
  - Each eject is a `change_valid` pulse and subtracts that coin's value from `amount`.
  - A residue below 5 is dropped.
- `VM_COIN_CHANGE_EN` undefined:
  - CHANGE lasts 1 cycle.
  - `change_valid`=1 with `change_coin`=00 signals "return `amount` as a lump sum".
  - `amount` clears the following cycle.

## Test plan
- Restock: restock slot 2 with 10 units at price 35, then 7 more units. Expect stock 10; the second write gives ERROR and stock remains 10 (17>16).
- Exact pay: select slot 2, insert quarter+dime, `confirm`. Expect `product_valid` with id 2, stock 9, `amount` 0, return to IDLE with no change.
- Change, with `VM_COIN_CHANGE_EN`: price 35, insert 3 quarters (75), `confirm`. Expect vend, then change quarter, dime, nickel, then `amount`=0.
- Insufficient then top-up: price 35, insert a quarter, `confirm`. Expect INSUFFICIENT with credit 25. Then insert a dime and `confirm`: vend occurs.
- Timeout: select an available slot, insert a nickel, idle TIMEOUT+1 cycles. Expect TIMEOUT, refund of 5, IDLE, stock unchanged.
- Empty slot, and reset mid-COLLECT: selecting an empty slot gives OUT_OF_STOCK and IDLE. Asserting `hrst_n`=0 in COLLECT gives all outputs at reset values the next cycle.
